// File: rtl/uriscv_csr_irq.sv
// Machine-mode CSR file and trap unit for uRISC-V with NUM_IRQ fixed-priority platform interrupts.
// Optional `URISCV_CSR_VECTORED_EN makes mtvec[0] writable and enables vectored interrupt dispatch.
module uriscv_csr_irq #(
    parameter int unsigned NUM_IRQ          = 4,
    parameter int unsigned SUPPORT_MINSTRET = 1,
    parameter logic [31:0] RESET_MTVEC      = 32'h0000_0000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               ext_intr_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [31:0]        cpu_id_i,
    input  logic               valid_i,
    input  logic               retire_i,
    input  logic [31:0]        pc_i,
    input  logic [31:0]        opcode_i,
    input  logic [31:0]        rs1_val_i,
    input  logic               excpn_invalid_inst_i,
    input  logic               excpn_lsu_align_i,
    input  logic [31:0]        mem_addr_i,
    output logic [31:0]        csr_rdata_o,
    output logic [31:0]        csr_mepc_o,
    output logic               exception_o,
    output logic [31:0]        exception_pc_o,
    output logic               irq_pending_o
);

    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MISA          = 12'h301;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MTVAL         = 12'h343;
    localparam logic [11:0] CSR_MIP           = 12'h344;
    localparam logic [11:0] CSR_MTIMECMP      = 12'h7C0;
    localparam logic [11:0] CSR_MTIMECMPH     = 12'h7C1;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_MHARTID       = 12'hF14;

    localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
    localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSN_MRET   = 32'h3020_0073;

    localparam logic [31:0] MIE_MASK = 32'h0000_0880 | (((32'h1 << NUM_IRQ) - 32'h1) << 16);
    localparam logic [31:0] MCOUNTINHIBIT_MASK = 32'h0000_0005;
`ifdef URISCV_CSR_VECTORED_EN
    localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFD;
`else
    localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFC;
`endif
`ifdef URISCV_SUPPORT_MULDIV
    localparam logic [31:0] MISA_VAL = 32'h4000_1100;
`else
    localparam logic [31:0] MISA_VAL = 32'h4000_0100;
`endif

    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mcountinhibit_q, mcountinhibit_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;

    logic [2:0]  funct3_c;
    logic [4:0]  rs1_c;
    logic [11:0] csr_addr_c;
    logic        is_csr_c;
    logic        is_ecall_c;
    logic        is_ebreak_c;
    logic        is_mret_c;
    logic [31:0] mip_c;
    logic [31:0] pend_c;
    logic [4:0]  irq_code_c;
    logic        irq_take_c;
    logic        trap_c;
    logic [31:0] trap_cause_c;
    logic [31:0] trap_val_c;
    logic [31:0] csr_src_c;
    logic [31:0] csr_wdata_c;
    logic        csr_we_c;
    logic        mret_c;

    assign funct3_c    = opcode_i[14:12];
    assign rs1_c       = opcode_i[19:15];
    assign csr_addr_c  = opcode_i[31:20];
    assign is_csr_c    = (opcode_i[6:0] == OPC_SYSTEM) && (funct3_c[1:0] != 2'b00);
    assign is_ecall_c  = (opcode_i == INSN_ECALL);
    assign is_ebreak_c = (opcode_i == INSN_EBREAK);
    assign is_mret_c   = (opcode_i == INSN_MRET);

    // Pending sources and fixed-priority interrupt code selection
    always_comb begin
        mip_c = '0;
        mip_c[11] = ext_intr_i;
        mip_c[7]  = (mcycle_q >= mtimecmp_q);
        mip_c[16 +: NUM_IRQ] = irq_i;
        pend_c = mip_c & mie_q;
        irq_code_c = 5'd0;
        for (int n = int'(NUM_IRQ) - 1; n >= 0; n--) begin
            if (pend_c[16 + n]) irq_code_c = 5'(16 + n);
        end
        if (pend_c[7])  irq_code_c = 5'd7;
        if (pend_c[11]) irq_code_c = 5'd11;
    end

    assign irq_pending_o = |pend_c;
    assign irq_take_c    = valid_i & mstatus_mie_q & irq_pending_o;

    // Trap arbitration: interrupt > illegal > ECALL > EBREAK > misaligned
    always_comb begin
        trap_c       = 1'b0;
        trap_cause_c = '0;
        trap_val_c   = '0;
        if (irq_take_c) begin
            trap_c       = 1'b1;
            trap_cause_c = {1'b1, 26'b0, irq_code_c};
        end else if (valid_i && excpn_invalid_inst_i) begin
            trap_c       = 1'b1;
            trap_cause_c = 32'd2;
            trap_val_c   = opcode_i;
        end else if (valid_i && is_ecall_c) begin
            trap_c       = 1'b1;
            trap_cause_c = 32'd11;
        end else if (valid_i && is_ebreak_c) begin
            trap_c       = 1'b1;
            trap_cause_c = 32'd3;
        end else if (valid_i && excpn_lsu_align_i) begin
            trap_c       = 1'b1;
            trap_cause_c = opcode_i[5] ? 32'd6 : 32'd4;
            trap_val_c   = mem_addr_i;
        end
    end

    assign exception_o = trap_c;
    assign csr_mepc_o  = mepc_q;

    always_comb begin
        exception_pc_o = {mtvec_q[31:2], 2'b00};
`ifdef URISCV_CSR_VECTORED_EN
        if (irq_take_c && mtvec_q[0]) begin
            exception_pc_o = {mtvec_q[31:2], 2'b00} + {25'b0, irq_code_c, 2'b00};
        end
`endif
    end

    // CSR read mux
    always_comb begin
        csr_rdata_o = '0;
        case (csr_addr_c)
            CSR_MSTATUS:       csr_rdata_o = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
            CSR_MISA:          csr_rdata_o = MISA_VAL;
            CSR_MIE:           csr_rdata_o = mie_q;
            CSR_MTVEC:         csr_rdata_o = mtvec_q;
            CSR_MCOUNTINHIBIT: csr_rdata_o = mcountinhibit_q;
            CSR_MSCRATCH:      csr_rdata_o = mscratch_q;
            CSR_MEPC:          csr_rdata_o = mepc_q;
            CSR_MCAUSE:        csr_rdata_o = mcause_q;
            CSR_MTVAL:         csr_rdata_o = mtval_q;
            CSR_MIP:           csr_rdata_o = mip_c;
            CSR_MTIMECMP:      csr_rdata_o = mtimecmp_q[31:0];
            CSR_MTIMECMPH:     csr_rdata_o = mtimecmp_q[63:32];
            CSR_MCYCLE:        csr_rdata_o = mcycle_q[31:0];
            CSR_MCYCLEH:       csr_rdata_o = mcycle_q[63:32];
            CSR_MINSTRET:      csr_rdata_o = minstret_q[31:0];
            CSR_MINSTRETH:     csr_rdata_o = minstret_q[63:32];
            CSR_MHARTID:       csr_rdata_o = cpu_id_i;
            default:           csr_rdata_o = '0;
        endcase
    end

    // Write data for RW/RS/RC and immediate variants; RS/RC with x0/zero immediate never write
    always_comb begin
        csr_src_c = funct3_c[2] ? 32'(rs1_c) : rs1_val_i;
        case (funct3_c[1:0])
            2'b10:   csr_wdata_c = csr_rdata_o | csr_src_c;
            2'b11:   csr_wdata_c = csr_rdata_o & ~csr_src_c;
            default: csr_wdata_c = csr_src_c;
        endcase
        csr_we_c = valid_i & is_csr_c & ~trap_c & ((funct3_c[1:0] == 2'b01) | (rs1_c != 5'd0));
        mret_c   = valid_i & is_mret_c & ~trap_c;
    end

    // Next-state: counters, CSR writes, trap entry and MRET
    always_comb begin
        mstatus_mie_d   = mstatus_mie_q;
        mstatus_mpie_d  = mstatus_mpie_q;
        mie_d           = mie_q;
        mtvec_d         = mtvec_q;
        mcountinhibit_d = mcountinhibit_q;
        mscratch_d      = mscratch_q;
        mepc_d          = mepc_q;
        mcause_d        = mcause_q;
        mtval_d         = mtval_q;
        mtimecmp_d      = mtimecmp_q;
        mcycle_d        = mcountinhibit_q[0] ? mcycle_q : mcycle_q + 64'd1;
        minstret_d      = (retire_i && !mcountinhibit_q[2]) ? minstret_q + 64'd1 : minstret_q;

        if (csr_we_c) begin
            case (csr_addr_c)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = csr_wdata_c[3];
                    mstatus_mpie_d = csr_wdata_c[7];
                end
                CSR_MIE:           mie_d           = csr_wdata_c & MIE_MASK;
                CSR_MTVEC:         mtvec_d         = csr_wdata_c & MTVEC_MASK;
                CSR_MCOUNTINHIBIT: mcountinhibit_d = csr_wdata_c & MCOUNTINHIBIT_MASK;
                CSR_MSCRATCH:      mscratch_d      = csr_wdata_c;
                CSR_MEPC:          mepc_d          = {csr_wdata_c[31:2], 2'b00};
                CSR_MCAUSE:        mcause_d        = csr_wdata_c;
                CSR_MTVAL:         mtval_d         = csr_wdata_c;
                CSR_MTIMECMP:      mtimecmp_d      = {mtimecmp_q[63:32], csr_wdata_c};
                CSR_MTIMECMPH:     mtimecmp_d      = {csr_wdata_c, mtimecmp_q[31:0]};
                CSR_MCYCLE:        mcycle_d        = {mcycle_q[63:32], csr_wdata_c};
                CSR_MCYCLEH:       mcycle_d        = {csr_wdata_c, mcycle_q[31:0]};
                CSR_MINSTRET:      minstret_d      = {minstret_q[63:32], csr_wdata_c};
                CSR_MINSTRETH:     minstret_d      = {csr_wdata_c, minstret_q[31:0]};
                default: ;
            endcase
        end

        if (trap_c) begin
            mepc_d         = {pc_i[31:2], 2'b00};
            mcause_d       = trap_cause_c;
            mtval_d        = trap_val_c;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_c) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end

        if (SUPPORT_MINSTRET == 0) minstret_d = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mstatus_mie_q   <= 1'b0;
            mstatus_mpie_q  <= 1'b0;
            mie_q           <= '0;
            mtvec_q         <= RESET_MTVEC & MTVEC_MASK;
            mcountinhibit_q <= '0;
            mscratch_q      <= '0;
            mepc_q          <= '0;
            mcause_q        <= '0;
            mtval_q         <= '0;
            mcycle_q        <= '0;
            minstret_q      <= '0;
            mtimecmp_q      <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            mstatus_mie_q   <= mstatus_mie_d;
            mstatus_mpie_q  <= mstatus_mpie_d;
            mie_q           <= mie_d;
            mtvec_q         <= mtvec_d;
            mcountinhibit_q <= mcountinhibit_d;
            mscratch_q      <= mscratch_d;
            mepc_q          <= mepc_d;
            mcause_q        <= mcause_d;
            mtval_q         <= mtval_d;
            mcycle_q        <= mcycle_d;
            minstret_q      <= minstret_d;
            mtimecmp_q      <= mtimecmp_d;
        end
    end

endmodule

// File: tb/tb_uriscv_csr_irq.sv
// Scoreboard bench for uriscv_csr_irq: expectations queued at stimulus time, drained against DUT outputs.
module tb_uriscv_csr_irq;

    localparam int unsigned NUM_IRQ = 4;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] ECALL   = 32'h0000_0073;
    localparam logic [31:0] EBREAK  = 32'h0010_0073;
    localparam logic [31:0] MRET    = 32'h3020_0073;
    localparam logic [31:0] HARTID  = 32'h0000_0A5A;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               ext_intr_i;
    logic [NUM_IRQ-1:0] irq_i;
    logic [31:0]        cpu_id_i;
    logic               valid_i;
    logic               retire_i;
    logic [31:0]        pc_i;
    logic [31:0]        opcode_i;
    logic [31:0]        rs1_val_i;
    logic               excpn_invalid_inst_i;
    logic               excpn_lsu_align_i;
    logic [31:0]        mem_addr_i;
    logic [31:0]        csr_rdata_o;
    logic [31:0]        csr_mepc_o;
    logic               exception_o;
    logic [31:0]        exception_pc_o;
    logic               irq_pending_o;

    uriscv_csr_irq #(.NUM_IRQ(NUM_IRQ), .SUPPORT_MINSTRET(1), .RESET_MTVEC(32'h0000_0000)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .ext_intr_i(ext_intr_i), .irq_i(irq_i),
        .cpu_id_i(cpu_id_i), .valid_i(valid_i), .retire_i(retire_i), .pc_i(pc_i),
        .opcode_i(opcode_i), .rs1_val_i(rs1_val_i),
        .excpn_invalid_inst_i(excpn_invalid_inst_i), .excpn_lsu_align_i(excpn_lsu_align_i),
        .mem_addr_i(mem_addr_i), .csr_rdata_o(csr_rdata_o), .csr_mepc_o(csr_mepc_o),
        .exception_o(exception_o), .exception_pc_o(exception_pc_o), .irq_pending_o(irq_pending_o)
    );

    always #5 clk_i = ~clk_i;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic [31:0] got_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic logic [31:0] csr_insn(input logic [11:0] addr, input logic [4:0] rs1,
                                             input logic [2:0] f3);
        return {addr, rs1, f3, 5'd1, 7'b1110011};
    endfunction

    task automatic expect_val(input string tag, input logic [31:0] val);
        tag_q.push_back(tag);
        exp_q.push_back(val);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        ext_intr_i = 1'b0; irq_i = '0; cpu_id_i = HARTID; valid_i = 1'b0; retire_i = 1'b0;
        pc_i = '0; opcode_i = NOP; rs1_val_i = '0; excpn_invalid_inst_i = 1'b0;
        excpn_lsu_align_i = 1'b0; mem_addr_i = '0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
        opcode_i = csr_insn(addr, 5'd1, 3'b001);
        rs1_val_i = data;
        valid_i = 1'b1;
        @(posedge clk_i);
        #1 valid_i = 1'b0;
        opcode_i = NOP;
    endtask

    task automatic csr_read(input logic [11:0] addr, output logic [31:0] data);
        opcode_i = csr_insn(addr, 5'd0, 3'b010);
        #1 data = csr_rdata_o;
        opcode_i = NOP;
    endtask

    task automatic exec_step(input logic [31:0] pc, input logic [31:0] op,
                             output logic exc, output logic [31:0] epc);
        pc_i = pc; opcode_i = op; valid_i = 1'b1;
        #1 exc = exception_o;
        epc = exception_pc_o;
        @(posedge clk_i);
        #1 valid_i = 1'b0; opcode_i = NOP;
        excpn_invalid_inst_i = 1'b0; excpn_lsu_align_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        repeat (8) @(posedge clk_i);
        #1 csr_write(12'h341, 32'h44);
        #2 rst_i = 1'b1;
        #1;
        expect_val("rst_exception_o", 32'd0);     got_q.push_back(32'(exception_o));
        expect_val("rst_exception_pc", 32'd0);    got_q.push_back(exception_pc_o);
        expect_val("rst_irq_pending", 32'd0);     got_q.push_back(32'(irq_pending_o));
        expect_val("rst_mepc_o", 32'd0);          got_q.push_back(csr_mepc_o);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        expect_val("rst_mcycle", 32'd0);          csr_read(12'hB00, d); got_q.push_back(d);
        expect_val("rst_mtimecmp", 32'hFFFF_FFFF);  csr_read(12'h7C0, d); got_q.push_back(d);
        expect_val("rst_mtimecmph", 32'hFFFF_FFFF); csr_read(12'h7C1, d); got_q.push_back(d);
        expect_val("rst_mip", 32'd0);             csr_read(12'h344, d); got_q.push_back(d);
        expect_val("rst_mstatus", 32'h0000_1800); csr_read(12'h300, d); got_q.push_back(d);
`ifdef URISCV_SUPPORT_MULDIV
        expect_val("misa", 32'h4000_1100);        csr_read(12'h301, d); got_q.push_back(d);
`else
        expect_val("misa", 32'h4000_0100);        csr_read(12'h301, d); got_q.push_back(d);
`endif
        expect_val("mhartid", HARTID);            csr_read(12'hF14, d); got_q.push_back(d);
        repeat (5) @(posedge clk_i);
        #1 expect_val("mcycle_after_5", 32'd5);   csr_read(12'hB00, d); got_q.push_back(d);
        while (got_q.size() != 0) begin
            logic [31:0] e, g; string t;
            e = exp_q.pop_front(); t = tag_q.pop_front(); g = got_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL %s: got %h expected %h", t, g, e); end
        end
    endtask

    task automatic test_timer_irq();
        logic [31:0] d, rd_at, pc_at;
        logic hit;
        do_reset();
        csr_write(12'h305, 32'h400);
        csr_write(12'h7C0, 32'h20);
        csr_write(12'h7C1, 32'h0);
        csr_write(12'h304, 32'h80);
        csr_write(12'h300, 32'h8);
        expect_val("tmr_not_yet_pending", 32'd0); got_q.push_back(32'(irq_pending_o));
        pc_i = 32'h200; opcode_i = csr_insn(12'hB00, 5'd0, 3'b010); valid_i = 1'b1;
        hit = 1'b0; rd_at = '0; pc_at = '0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (exception_o) begin
                hit = 1'b1; rd_at = csr_rdata_o; pc_at = exception_pc_o;
                break;
            end
            @(posedge clk_i);
        end
        expect_val("tmr_trap_seen", 32'd1);       got_q.push_back(32'(hit));
        expect_val("tmr_mcycle_at_trap", 32'h20); got_q.push_back(rd_at);
        expect_val("tmr_exception_pc", 32'h400);  got_q.push_back(pc_at);
        @(posedge clk_i);
        #1 valid_i = 1'b0; opcode_i = NOP;
        expect_val("tmr_mcause", 32'h8000_0007);  csr_read(12'h342, d); got_q.push_back(d);
        expect_val("tmr_mepc", 32'h200);          csr_read(12'h341, d); got_q.push_back(d);
        expect_val("tmr_mstatus", 32'h0000_1880); csr_read(12'h300, d); got_q.push_back(d);
        expect_val("tmr_mepc_o", 32'h200);        got_q.push_back(csr_mepc_o);
        expect_val("tmr_pending_mie0", 32'd1);    got_q.push_back(32'(irq_pending_o));
        expect_val("tmr_exc_idle", 32'd0);        got_q.push_back(32'(exception_o));
        while (got_q.size() != 0) begin
            logic [31:0] e, g; string t;
            e = exp_q.pop_front(); t = tag_q.pop_front(); g = got_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL %s: got %h expected %h", t, g, e); end
        end
    endtask

    task automatic test_irq_priority();
        logic [31:0] d, epc;
        logic exc;
        do_reset();
        irq_i = 4'b0110; ext_intr_i = 1'b1;
        csr_write(12'h304, 32'h0006_0000);
        csr_write(12'h300, 32'h8);
        expect_val("prio_pending", 32'd1);          got_q.push_back(32'(irq_pending_o));
        expect_val("prio_mip", 32'h0006_0800);      csr_read(12'h344, d); got_q.push_back(d);
        exec_step(32'h300, NOP, exc, epc);
        expect_val("prio_exc_irq1", 32'd1);         got_q.push_back(32'(exc));
        expect_val("prio_mcause_irq1", 32'h8000_0011); csr_read(12'h342, d); got_q.push_back(d);
        csr_write(12'h304, 32'h0006_0800);
        csr_write(12'h300, 32'h8);
        exec_step(32'h304, NOP, exc, epc);
        expect_val("prio_exc_mei", 32'd1);          got_q.push_back(32'(exc));
        expect_val("prio_mcause_mei", 32'h8000_000B); csr_read(12'h342, d); got_q.push_back(d);
        irq_i = '0; ext_intr_i = 1'b0;
        expect_val("prio_mip_clear", 32'd0);        csr_read(12'h344, d); got_q.push_back(d);
        expect_val("prio_pending_clear", 32'd0);    got_q.push_back(32'(irq_pending_o));
        csr_write(12'h304, 32'hFFFF_FFFF);
        expect_val("mie_mask", 32'h000F_0880);      csr_read(12'h304, d); got_q.push_back(d);
        // Interrupt beats a simultaneous illegal instruction
        ext_intr_i = 1'b1;
        csr_write(12'h300, 32'h8);
        excpn_invalid_inst_i = 1'b1;
        exec_step(32'h240, 32'hFFFF_FFFF, exc, epc);
        ext_intr_i = 1'b0;
        expect_val("irq_vs_ill_mcause", 32'h8000_000B); csr_read(12'h342, d); got_q.push_back(d);
        expect_val("irq_vs_ill_mepc", 32'h240);     csr_read(12'h341, d); got_q.push_back(d);
        while (got_q.size() != 0) begin
            logic [31:0] e, g; string t;
            e = exp_q.pop_front(); t = tag_q.pop_front(); g = got_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL %s: got %h expected %h", t, g, e); end
        end
    endtask

    task automatic test_counters();
        logic [31:0] d;
        do_reset();
        csr_write(12'hB00, 32'hFFFF_FFFF);
        expect_val("cnt_mcycle_written", 32'hFFFF_FFFF); csr_read(12'hB00, d); got_q.push_back(d);
        expect_val("cnt_mcycleh_before", 32'd0);    csr_read(12'hB80, d); got_q.push_back(d);
        @(posedge clk_i);
        #1 expect_val("cnt_mcycle_carry", 32'd0);   csr_read(12'hB00, d); got_q.push_back(d);
        expect_val("cnt_mcycleh_carry", 32'd1);     csr_read(12'hB80, d); got_q.push_back(d);
        retire_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 retire_i = 1'b0;
        expect_val("cnt_minstret", 32'd3);          csr_read(12'hB02, d); got_q.push_back(d);
        csr_write(12'h320, 32'hFFFF_FFFF);
        csr_write(12'hB00, 32'h1234);
        csr_write(12'hB02, 32'h55);
        retire_i = 1'b1;
        repeat (5) @(posedge clk_i);
        #1 retire_i = 1'b0;
        expect_val("inh_mcycle", 32'h1234);         csr_read(12'hB00, d); got_q.push_back(d);
        expect_val("inh_mcycleh", 32'd1);          csr_read(12'hB80, d); got_q.push_back(d);
        expect_val("inh_minstret", 32'h55);         csr_read(12'hB02, d); got_q.push_back(d);
        expect_val("inh_mask", 32'h5);              csr_read(12'h320, d); got_q.push_back(d);
        csr_write(12'hB80, 32'hFFFF_FFFF);
        csr_write(12'hB00, 32'hFFFF_FFFF);
        csr_write(12'h320, 32'h0);
        @(posedge clk_i);
        #1 expect_val("wrap_mcycle", 32'd0);        csr_read(12'hB00, d); got_q.push_back(d);
        expect_val("wrap_mcycleh", 32'd0);          csr_read(12'hB80, d); got_q.push_back(d);
        while (got_q.size() != 0) begin
            logic [31:0] e, g; string t;
            e = exp_q.pop_front(); t = tag_q.pop_front(); g = got_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL %s: got %h expected %h", t, g, e); end
        end
    endtask

    task automatic test_exceptions();
        logic [31:0] d, epc;
        logic exc;
        do_reset();
        csr_write(12'h305, 32'h800);
        csr_write(12'h300, 32'h8);
        excpn_invalid_inst_i = 1'b1;
        exec_step(32'h100, 32'hFFFF_FFFF, exc, epc);
        expect_val("ill_exc", 32'd1);               got_q.push_back(32'(exc));
        expect_val("ill_target", 32'h800);          got_q.push_back(epc);
        expect_val("ill_mcause", 32'd2);            csr_read(12'h342, d); got_q.push_back(d);
        expect_val("ill_mtval", 32'hFFFF_FFFF);     csr_read(12'h343, d); got_q.push_back(d);
        expect_val("ill_mepc", 32'h100);            csr_read(12'h341, d); got_q.push_back(d);
        expect_val("ill_mstatus", 32'h0000_1880);   csr_read(12'h300, d); got_q.push_back(d);
        exec_step(32'h800, MRET, exc, epc);
        expect_val("mret_no_trap", 32'd0);          got_q.push_back(32'(exc));
        expect_val("mret_mstatus", 32'h0000_1888);  csr_read(12'h300, d); got_q.push_back(d);
        exec_step(32'h104, ECALL, exc, epc);
        expect_val("ecall_exc", 32'd1);             got_q.push_back(32'(exc));
        expect_val("ecall_mcause", 32'd11);         csr_read(12'h342, d); got_q.push_back(d);
        expect_val("ecall_mtval", 32'd0);           csr_read(12'h343, d); got_q.push_back(d);
        exec_step(32'h108, EBREAK, exc, epc);
        expect_val("ebreak_mcause", 32'd3);         csr_read(12'h342, d); got_q.push_back(d);
        excpn_lsu_align_i = 1'b1; mem_addr_i = 32'h1003;
        exec_step(32'h10C, 32'h0010_2023, exc, epc);
        expect_val("sto_align_mcause", 32'd6);      csr_read(12'h342, d); got_q.push_back(d);
        expect_val("sto_align_mtval", 32'h1003);    csr_read(12'h343, d); got_q.push_back(d);
        excpn_lsu_align_i = 1'b1; mem_addr_i = 32'h2001;
        exec_step(32'h110, 32'h0000_2083, exc, epc);
        expect_val("ld_align_mcause", 32'd4);       csr_read(12'h342, d); got_q.push_back(d);
        expect_val("ld_align_mepc", 32'h110);       csr_read(12'h341, d); got_q.push_back(d);
        while (got_q.size() != 0) begin
            logic [31:0] e, g; string t;
            e = exp_q.pop_front(); t = tag_q.pop_front(); g = got_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL %s: got %h expected %h", t, g, e); end
        end
    endtask

    task automatic test_csr_ops();
        logic [31:0] d, epc;
        logic exc;
        do_reset();
        rs1_val_i = 32'hDEAD;
        excpn_invalid_inst_i = 1'b1;
        exec_step(32'h0, csr_insn(12'h340, 5'd1, 3'b001), exc, epc);
        expect_val("sup_exc", 32'd1);               got_q.push_back(32'(exc));
        expect_val("sup_mscratch", 32'd0);          csr_read(12'h340, d); got_q.push_back(d);
        rs1_val_i = 32'hF0;
        exec_step(32'h4, csr_insn(12'h340, 5'd0, 3'b010), exc, epc);
        expect_val("rs_x0_nowrite", 32'd0);         csr_read(12'h340, d); got_q.push_back(d);
        exec_step(32'h8, csr_insn(12'h340, 5'h1F, 3'b101), exc, epc);
        expect_val("csrrwi", 32'h1F);               csr_read(12'h340, d); got_q.push_back(d);
        exec_step(32'hC, csr_insn(12'h340, 5'h03, 3'b111), exc, epc);
        expect_val("csrrci", 32'h1C);               csr_read(12'h340, d); got_q.push_back(d);
        rs1_val_i = 32'h100;
        exec_step(32'h10, csr_insn(12'h340, 5'd2, 3'b010), exc, epc);
        expect_val("csrrs", 32'h11C);               csr_read(12'h340, d); got_q.push_back(d);
        csr_write(12'h344, 32'hFFFF_FFFF);
        expect_val("mip_ro", 32'd0);                csr_read(12'h344, d); got_q.push_back(d);
        csr_write(12'h341, 32'h1237);
        expect_val("mepc_lsb", 32'h1234);           csr_read(12'h341, d); got_q.push_back(d);
        while (got_q.size() != 0) begin
            logic [31:0] e, g; string t;
            e = exp_q.pop_front(); t = tag_q.pop_front(); g = got_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL %s: got %h expected %h", t, g, e); end
        end
    endtask

    task automatic test_vectored();
        logic [31:0] d, epc;
        logic exc;
        do_reset();
`ifdef URISCV_CSR_VECTORED_EN
        csr_write(12'h305, 32'h1001);
        expect_val("vec_mtvec", 32'h1001);          csr_read(12'h305, d); got_q.push_back(d);
        expect_val("vec_mti_target", 32'h101C);
`else
        csr_write(12'h305, 32'h1003);
        expect_val("vec_mtvec", 32'h1000);          csr_read(12'h305, d); got_q.push_back(d);
        expect_val("vec_mti_target", 32'h1000);
`endif
        csr_write(12'h7C0, 32'h0);
        csr_write(12'h7C1, 32'h0);
        csr_write(12'h304, 32'h80);
        csr_write(12'h300, 32'h8);
        exec_step(32'h500, NOP, exc, epc);
        got_q.push_back(epc);
        expect_val("vec_mti_exc", 32'd1);           got_q.push_back(32'(exc));
        exec_step(32'h504, ECALL, exc, epc);
        expect_val("vec_ecall_target", 32'h1000);   got_q.push_back(epc);
        expect_val("vec_ecall_mcause", 32'd11);     csr_read(12'h342, d); got_q.push_back(d);
        while (got_q.size() != 0) begin
            logic [31:0] e, g; string t;
            e = exp_q.pop_front(); t = tag_q.pop_front(); g = got_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL %s: got %h expected %h", t, g, e); end
        end
    endtask

    initial begin
        test_reset();
        test_timer_irq();
        test_irq_priority();
        test_counters();
        test_exceptions();
        test_csr_ops();
        test_vectored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uriscv_csr_irq.md
Name: uriscv_csr_irq

Overview:
Machine-mode CSR file and trap unit for uRISC-V, parametrised successor to the single-IRQ CSR block.
- Adds NUM_IRQ level-sensitive platform interrupt lines with fixed priority.
- Adds full 64-bit mcycle, minstret and mtimecmp, plus mcountinhibit.
- Sits beside the execute stage: decodes CSR/SYSTEM opcodes, holds trap state, returns read data and trap target PC to the fetch logic.

Parameters:
NUM_IRQ, 4, platform interrupt lines (1..16), mapped to mip/mie bits [16+n]
SUPPORT_MINSTRET, 1, implement minstret/minstreth; 0 = read as zero
RESET_MTVEC, 32'h0000_0000, mtvec reset value

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
ext_intr_i  in  1  machine external interrupt (MEIP, mip[11]), level
irq_i  in  NUM_IRQ  platform interrupts, level, mip[16+n]
cpu_id_i  in  32  mhartid value
valid_i  in  1  instruction in execute this cycle
retire_i  in  1  instruction retired this cycle (minstret increment)
pc_i  in  32  PC of executing instruction
opcode_i  in  32  instruction word
rs1_val_i  in  32  rs1 operand
excpn_invalid_inst_i  in  1  illegal instruction
excpn_lsu_align_i  in  1  misaligned load/store
mem_addr_i  in  32  faulting address
csr_rdata_o  out  32  CSR read data (combinational)
csr_mepc_o  out  32  mepc for MRET
exception_o  out  1  trap taken this cycle
exception_pc_o  out  32  trap target PC
irq_pending_o  out  1  |(mip & mie), ignores mstatus.MIE (WFI wake)

Behaviour:
- Reset (async): all CSRs 0, except:
  - mtvec = RESET_MTVEC
  - mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF
  - mstatus.MPP reads 2'b11 always
- Reset output values: exception_o=0, irq_pending_o=0, csr_mepc_o=0; exception_pc_o=RESET_MTVEC.
- CSR ops: CSRRW/S/C and their immediate forms.
  - Write data lands in the register at the next clk edge; reads return the current registered value.
  - CSRRS/CSRRC with a zero source do not write.
  - Writes are suppressed when exception_o=1.
- Addresses:
  - Standard: mstatus 0x300, misa 0x301, mie 0x304, mtvec 0x305, mcountinhibit 0x320, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344, mcycle/h 0xB00/0xB80, minstret/h 0xB02/0xB82, mhartid 0xF14.
  - Custom: mtimecmp/h 0x7C0/0x7C1.
- mip is read-only:
  - bit11 = ext_intr_i
  - bit7 = (mcycle >= mtimecmp), unsigned 64-bit compare on registered values
  - bits[16+n] = irq_i[n]
  - Writes are ignored. Pending clears only when the source deasserts or mtimecmp is raised.
- mie writable bits: 11, 7, [16+NUM_IRQ-1:16]; all others read 0.
- Counters:
  - mcycle increments every cycle unless mcountinhibit[0].
  - minstret increments on retire_i unless mcountinhibit[2].
  - 64-bit wrap to 0.
  - A CSR write to either half takes precedence over that cycle's increment for the whole counter.
  - mepc[1:0] and mtvec[1] read 0.
- Interrupt take:
  - take = valid_i & mstatus.MIE & |(mip & mie).
  - Priority: MEI(11) > MTI(7) > irq_i[0] > irq_i[1] > ...
  - mcause = {1'b1, 26'b0, code}.
- Trap priority, highest first: interrupt > illegal (mcause 2, mtval=opcode) > ECALL (11) > EBREAK (3) > misaligned (4 load / 6 store, mtval=mem_addr_i).
  - ECALL/EBREAK: mtval=0.
- Trap entry (same cycle, registered next edge):
  - mepc=pc_i, MPIE=MIE, MIE=0.
  - exception_o=1 combinationally for interrupt/illegal/misaligned, and also asserted for ECALL/EBREAK.
  - exception_pc_o = {mtvec[31:2],2'b00} (direct).
- MRET: MIE=MPIE, MPIE=1; no trap.
- Simultaneous interrupt and illegal instruction: the interrupt wins; mepc = that PC, which is re-executed after MRET.
- misa = RV32I, plus M if the shared define says so.

Optional Feature:
URISCV_CSR_VECTORED_EN.
- Defined:
  - mtvec[0] is writable (MODE).
  - With MODE=1, interrupt traps target {mtvec[31:2],2'b00} + 4*code.
  - Exceptions always target the base.
- Undefined:
  - mtvec[1:0] read 0; all traps direct.

Test Plan:
1. Reset mid-count, then release → mcycle=0, mtimecmp=all ones, exception_o=0, mip=0; mcycle reads 5 after 5 clocks.
2. Write mtimecmp=0x20, mtimecmph=0, mie[7]=1, mstatus.MIE=1; valid_i held → exception_o at mcycle>=0x20, mcause=0x8000_0007, mepc=pc_i, MIE=0, MPIE=1.
3. irq_i=4'b0110 with mie[17],mie[18]=1 and ext_intr_i=1, mie[11]=0 → mcause=0x8000_0011 (irq_i[1] wins); then set mie[11] → next trap mcause=0x8000_000B.
4. mcycle=0xFFFF_FFFF then 1 clock → mcycleh increments by 1, mcycle=0. Write mcountinhibit=0x5 → both counters frozen; retire_i pulses ignored.
5. Illegal opcode 0xFFFF_FFFF at pc 0x100 → mcause=2, mtval=0xFFFF_FFFF, mepc=0x100; MRET → MIE restored, MPIE=1.
6. URISCV_CSR_VECTORED_EN, mtvec=0x1001, MTI trap → exception_pc_o=0x101C; ECALL → exception_pc_o=0x1000, mcause=11.
